// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan controller.
//   scan_state_t : GAP (all digits dark) / SHOW (one digit lit)
//   disp_word_t  : 16-bit hex value plus per-digit decimal points
//   SEG_TABLE    : hex -> segment decode, active-low, bit order g..a
//   SEG_OFF / CS_OFF : idle (dark) values for Dis / Cs
package seg_pkg;

  typedef enum logic {ST_GAP, ST_SHOW} scan_state_t;

  typedef struct packed {
    logic [15:0] val;
    logic [3:0]  dp;
  } disp_word_t;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] CS_OFF  = 4'hF;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
  };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex digit to seven-segment decoder.
//   i_hex : 4-bit nibble
//   o_seg : segments g..a, active-low
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_TABLE[i_hex];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scan scheduler for a 4-digit multiplexed seven-segment display.
// Time-shares the segment bus between digits 0..3 with a blanking gap
// between digits; new values are taken through valid/ready into a
// pending buffer and copied to the displayed shadow only at the frame
// boundary, so a frame never shows a mix of two values.
//   CLK, RST          : clock, async active-low reset
//   value, dp_mask    : 4 hex nibbles (nibble 0 = rightmost) + dp per digit
//   value_vld/_rdy    : input handshake
//   lz_en             : leading-zero blanking, used live
//   Dis               : segments, active-low, Dis[7]=dp (registered)
//   Cs                : digit selects, active-low one-cold (registered)
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIV   = 50000,
  parameter int BLANK = 500
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] value,
  input  logic [3:0]  dp_mask,
  input  logic        value_vld,
  output logic        value_rdy,
  input  logic        lz_en,
  output logic [7:0]  Dis,
  output logic [3:0]  Cs
);

  localparam int CNT_MAX = (DIV > BLANK) ? DIV : BLANK;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);

  scan_state_t   r_state, w_state_nxt;
  logic [1:0]    r_idx, w_idx_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  disp_word_t    r_shadow, r_pend, w_shadow_nxt;
  logic          r_pend_full;
  logic [3:0]    r_cs, w_cs_nxt;
  logic [7:0]    r_dis, w_dis_nxt;
  logic          w_xfer, w_accept, w_blank;
  logic [3:0]    w_nib;
  logic [6:0]    w_seg;
  logic [15:0]   w_hi;

  // Frame boundary: last gap cycle before digit 0 lights.
  assign w_xfer    = (r_state == ST_GAP) && (r_idx == 2'd3) && (r_cnt == BLANK_LAST);
  assign value_rdy = !r_pend_full || w_xfer;
  assign w_accept  = value_vld && value_rdy;

  assign w_shadow_nxt = (w_xfer && r_pend_full) ? r_pend : r_shadow;

  // Next-state scheduling
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt + 1'b1;
    case (r_state)
      ST_GAP: if (r_cnt == BLANK_LAST) begin
        w_state_nxt = ST_SHOW;
        w_idx_nxt   = r_idx + 2'd1;
        w_cnt_nxt   = '0;
      end
      ST_SHOW: if (r_cnt == DIV_LAST) begin
        w_state_nxt = ST_GAP;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = ST_GAP;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are computed from the next state (including a shadow update
  // on this edge) so Cs and Dis switch together with the state and never
  // pair a digit with stale segment data.
  assign w_nib = w_shadow_nxt.val[{w_idx_nxt, 2'b00} +: 4];
  assign w_hi  = w_shadow_nxt.val >> {w_idx_nxt, 2'b00};
  assign w_blank = lz_en && (w_idx_nxt != 2'd0) && (w_hi == 16'h0);

  hex_to_seg u_dec (
    .i_hex (w_nib),
    .o_seg (w_seg)
  );

  always_comb begin
    w_cs_nxt  = CS_OFF;
    w_dis_nxt = SEG_OFF;
    if (w_state_nxt == ST_SHOW && !w_blank) begin
      w_cs_nxt  = ~(4'b0001 << w_idx_nxt);
      w_dis_nxt = {~w_shadow_nxt.dp[w_idx_nxt], w_seg};
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= ST_GAP;
      r_idx       <= 2'd3;
      r_cnt       <= '0;
      r_shadow    <= '0;
      r_pend      <= '0;
      r_pend_full <= 1'b0;
      r_cs        <= CS_OFF;
      r_dis       <= SEG_OFF;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_cnt    <= w_cnt_nxt;
      r_shadow <= w_shadow_nxt;
      r_cs     <= w_cs_nxt;
      r_dis    <= w_dis_nxt;
      // An accept on the xfer edge refills pending while shadow takes the old one.
      if (w_accept) begin
        r_pend      <= '{val: value, dp: dp_mask};
        r_pend_full <= 1'b1;
      end else if (w_xfer) begin
        r_pend_full <= 1'b0;
      end
    end
  end

  assign Cs  = r_cs;
  assign Dis = r_dis;

endmodule
